// File: rtl/axis_st_pkt_arb_pkg.sv
// rtl/axis_st_pkt_arb_pkg.sv - shared types and round-robin search for the packet arbiter
package axis_st_pkt_arb_pkg;

   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   localparam int RR_MAX = 16;

   // Scan last+1, last+2, ... (mod n); iterating downward lets the nearest hit win.
   function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] req,
                                          input logic [3:0]        last,
                                          input int                n);
      logic [3:0] pick;
      int         idx;
      pick = last;
      for (int k = RR_MAX; k >= 1; k--) begin
         if (k <= n) begin
            idx = (int'(last) + k) % n;
            if (req[idx[3:0]]) pick = idx[3:0];
         end
      end
      return pick;
   endfunction

endpackage

// File: rtl/axis_st_reg_slice.sv
// rtl/axis_st_reg_slice.sv - 2-entry full-throughput skid slice with registered upstream ready
module axis_st_reg_slice #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             s_valid,
   output logic             s_ready,
   input  logic [WIDTH-1:0] s_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data
);

   logic             skid_valid;
   logic [WIDTH-1:0] skid_data;
   logic             s_fire;

   // Ready depends only on the skid register, so m_ready never reaches upstream combinationally.
   assign s_ready = ~skid_valid;
   assign s_fire  = s_valid & s_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         m_valid    <= 1'b0;
         m_data     <= '0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
      end else if (!m_valid || m_ready) begin
         if (skid_valid) begin
            m_valid    <= 1'b1;
            m_data     <= skid_data;
            skid_valid <= 1'b0;
         end else begin
            m_valid <= s_fire;
            if (s_fire) m_data <= s_data;
         end
      end else if (s_fire) begin
         skid_valid <= 1'b1;
         skid_data  <= s_data;
      end
   end

endmodule

// File: rtl/axis_st_pkt_arb.sv
// rtl/axis_st_pkt_arb.sv - packet-locked round-robin merge of N AXI4-Stream requesters
module axis_st_pkt_arb #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32,
   parameter int ID_W   = 8,
   parameter int DEST_W = 4,
   parameter int USER_W = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [N_REQ-1:0]           s_tvalid,
   output logic [N_REQ-1:0]           s_tready,
   input  logic [N_REQ-1:0]           s_tlast,
   input  logic [N_REQ*DATA_W-1:0]    s_tdata,
   input  logic [N_REQ*DATA_W/8-1:0]  s_tstrb,
   input  logic [N_REQ*DATA_W/8-1:0]  s_tkeep,
   input  logic [N_REQ*ID_W-1:0]      s_tid,
   input  logic [N_REQ*DEST_W-1:0]    s_tdest,
   input  logic [N_REQ*USER_W-1:0]    s_tuser,
   output logic                       m_tvalid,
   input  logic                       m_tready,
   output logic [DATA_W-1:0]          m_tdata,
   output logic [DATA_W/8-1:0]        m_tstrb,
   output logic [DATA_W/8-1:0]        m_tkeep,
   output logic                       m_tlast,
   output logic [ID_W-1:0]            m_tid,
   output logic [DEST_W-1:0]          m_tdest,
   output logic [USER_W-1:0]          m_tuser,
   output logic                       grant_valid,
   output logic [$clog2(N_REQ)-1:0]   grant_idx
);

   import axis_st_pkt_arb_pkg::*;

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int KEEP_W = DATA_W / 8;
   localparam int PAY_W  = DATA_W + 2 * KEEP_W + 1 + ID_W + DEST_W + USER_W;

   state_t           state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] last_owner;
   logic             slice_in_ready;
   logic             sel_valid;
   logic             sel_last;
   logic             accept;
   logic [PAY_W-1:0] sel_payload;
   logic [PAY_W-1:0] out_payload;

   assign grant_idx = owner;
   assign sel_valid = (state == ST_LOCKED) & s_tvalid[owner];
   assign sel_last  = s_tlast[owner];
   assign accept    = sel_valid & slice_in_ready;

   assign sel_payload = {s_tdata[owner*DATA_W +: DATA_W],
                         s_tstrb[owner*KEEP_W +: KEEP_W],
                         s_tkeep[owner*KEEP_W +: KEEP_W],
                         s_tlast[owner],
                         s_tid[owner*ID_W +: ID_W],
                         s_tdest[owner*DEST_W +: DEST_W],
                         s_tuser[owner*USER_W +: USER_W]};

   assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_payload;

   always_comb begin
      s_tready = '0;
      if (state == ST_LOCKED) s_tready[owner] = slice_in_ready;
   end

   // The arbitration cycle accepts nothing; the lock drops only on an accepted tlast beat.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         owner       <= '0;
         last_owner  <= IDX_W'(N_REQ - 1);
         grant_valid <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|s_tvalid) begin
                  owner       <= IDX_W'(rr_next(RR_MAX'(s_tvalid), 4'(last_owner), N_REQ));
                  grant_valid <= 1'b1;
                  state       <= ST_LOCKED;
               end
            end
            ST_LOCKED: begin
               if (accept && sel_last) begin
                  state       <= ST_IDLE;
                  grant_valid <= 1'b0;
                  last_owner  <= owner;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   axis_st_reg_slice #(
      .WIDTH (PAY_W)
   ) u_slice (
      .clk     (clk),
      .reset   (reset),
      .s_valid (sel_valid),
      .s_ready (slice_in_ready),
      .s_data  (sel_payload),
      .m_valid (m_tvalid),
      .m_ready (m_tready),
      .m_data  (out_payload)
   );

endmodule

// File: tb/tb_axis_st_pkt_arb.sv
// tb/tb_axis_st_pkt_arb.sv - scoreboard bench for the packet-locked stream arbiter
module tb_axis_st_pkt_arb;

   localparam int N  = 4;
   localparam int DW = 32;
   localparam int KW = 4;
   localparam int IW = 8;
   localparam int TW = 4;
   localparam int UW = 1;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [N-1:0]      s_tvalid, s_tready, s_tlast;
   logic [N*DW-1:0]   s_tdata;
   logic [N*KW-1:0]   s_tstrb, s_tkeep;
   logic [N*IW-1:0]   s_tid;
   logic [N*TW-1:0]   s_tdest;
   logic [N*UW-1:0]   s_tuser;
   logic              m_tvalid, m_tready, m_tlast;
   logic [DW-1:0]     m_tdata;
   logic [KW-1:0]     m_tstrb, m_tkeep;
   logic [IW-1:0]     m_tid;
   logic [TW-1:0]     m_tdest;
   logic [UW-1:0]     m_tuser;
   logic              grant_valid;
   logic [1:0]        grant_idx;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic [3:0]  keep;
      logic        last;
      logic [7:0]  id;
      logic [3:0]  dest;
      logic        user;
   } beat_t;

   beat_t  src_mem [N][128];
   int     src_wr [N];
   int     src_base [N];
   int     src_rd [N];
   beat_t  exp_q[$];
   int     gexp_q[$];
   int     acc_cyc[$];
   int     n_cmp = 0;
   int     n_fail = 0;
   int     cyc = 0;
   int     acc_total = 0;
   int     out_n = 0;
   int     first_out = 0;
   int     last_out = 0;
   logic [N-1:0] pause;
   logic   lat_chk;

   axis_st_pkt_arb #(.N_REQ(N), .DATA_W(DW), .ID_W(IW), .DEST_W(TW), .USER_W(UW)) dut (
      .clk(clk), .reset(reset),
      .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tlast(s_tlast),
      .s_tdata(s_tdata), .s_tstrb(s_tstrb), .s_tkeep(s_tkeep),
      .s_tid(s_tid), .s_tdest(s_tdest), .s_tuser(s_tuser),
      .m_tvalid(m_tvalid), .m_tready(m_tready),
      .m_tdata(m_tdata), .m_tstrb(m_tstrb), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
      .m_tid(m_tid), .m_tdest(m_tdest), .m_tuser(m_tuser),
      .grant_valid(grant_valid), .grant_idx(grant_idx)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send(input int r, input logic [31:0] base, input int n);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.data = base + 32'(k);
         b.strb = 4'(k + 1);
         b.keep = 4'hF;
         b.last = (k == n - 1);
         b.id   = 8'(16 + r);
         b.dest = 4'(r);
         b.user = k[0];
         exp_q.push_back(b);
         src_mem[r][src_wr[r]] = b;
         src_wr[r]++;
      end
   endtask

   task automatic do_reset();
      tick();
      reset    = 1'b1;
      m_tready = 1'b1;
      pause    = '0;
      lat_chk  = 1'b0;
      tick();
      reset = 1'b0;
      exp_q.delete();
      gexp_q.delete();
      acc_cyc.delete();
      for (int i = 0; i < N; i++) src_base[i] = src_wr[i];
      out_n = 0;
      check("rst_grant_valid", 64'(grant_valid), 64'(0));
      check("rst_grant_idx", 64'(grant_idx), 64'(0));
      check("rst_s_tready", 64'(s_tready), 64'(0));
      check("rst_m_tvalid", 64'(m_tvalid), 64'(0));
      check("rst_m_payload", 64'({m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser}), 64'(0));
   endtask

   task automatic wait_drain(input string name);
      int t = 0;
      while ((exp_q.size() != 0 || gexp_q.size() != 0) && t < 300) begin
         tick();
         t++;
      end
      n_cmp++;
      if (exp_q.size() != 0 || gexp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_drain: %0d beats %0d grants outstanding, expected 0 0", name, exp_q.size(), gexp_q.size());
      end
   endtask

   task automatic wait_rd(input int r, input int n, input string name);
      int t = 0;
      while (src_rd[r] - src_base[r] < n && t < 100) begin
         tick();
         t++;
      end
      if (t >= 100) begin
         n_cmp++;
         n_fail++;
         $display("FAIL %s_wait: accepted %0d beats, expected at least %0d", name, src_rd[r] - src_base[r], n);
      end
   endtask

   // requester models: present queued beats, advance on observed handshakes
   initial begin
      logic [N-1:0] fire;
      beat_t        b;
      s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tstrb = '0; s_tkeep = '0;
      s_tid = '0; s_tdest = '0; s_tuser = '0;
      for (int i = 0; i < N; i++) src_rd[i] = 0;
      forever begin
         @(negedge clk);
         fire = s_tvalid & s_tready & {N{~reset}};
         for (int i = 0; i < N; i++)
            if (fire[i] && lat_chk) acc_cyc.push_back(cyc);
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (fire[i]) begin
               src_rd[i]++;
               acc_total++;
            end
            if (src_rd[i] < src_base[i]) src_rd[i] = src_base[i];
            if (!pause[i] && src_rd[i] < src_wr[i]) begin
               b = src_mem[i][src_rd[i]];
               s_tvalid[i] = 1'b1;
            end else begin
               b = '0;
               s_tvalid[i] = 1'b0;
            end
            s_tdata[i*DW +: DW] = b.data;
            s_tstrb[i*KW +: KW] = b.strb;
            s_tkeep[i*KW +: KW] = b.keep;
            s_tlast[i]          = b.last;
            s_tid[i*IW +: IW]   = b.id;
            s_tdest[i*TW +: TW] = b.dest;
            s_tuser[i*UW +: UW] = b.user;
         end
      end
   end

   // monitor: output beats, stall stability, latency and grant order
   initial begin
      beat_t got, held, e;
      logic  stall_prev = 1'b0;
      logic  gv_prev = 1'b0;
      int    ac;
      held = '0;
      forever begin
         @(negedge clk);
         got.data = m_tdata; got.strb = m_tstrb; got.keep = m_tkeep; got.last = m_tlast;
         got.id = m_tid; got.dest = m_tdest; got.user = m_tuser;
         if (reset) begin
            stall_prev = 1'b0;
            gv_prev    = 1'b0;
         end else begin
            if (stall_prev) check("stall_hold", 64'({m_tvalid, got}), 64'({1'b1, held}));
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got %0h expected none", got);
               end else begin
                  e = exp_q.pop_front();
                  check("beat", 64'(got), 64'(e));
               end
               if (lat_chk) begin
                  if (acc_cyc.size() == 0) begin
                     n_cmp++;
                     n_fail++;
                     $display("FAIL latency: output beat with no accepted input, expected one");
                  end else begin
                     ac = acc_cyc.pop_front();
                     check("latency", 64'(cyc - ac), 64'(1));
                  end
               end
               if (out_n == 0) first_out = cyc;
               last_out = cyc;
               out_n++;
            end
            stall_prev = m_tvalid && !m_tready;
            held = got;
            if (grant_valid && !gv_prev) begin
               if (gexp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL grant_order: got grant %0d expected none", grant_idx);
               end else begin
                  check("grant_order", 64'(grant_idx), 64'(gexp_q.pop_front()));
               end
            end
            gv_prev = grant_valid;
         end
      end
   end

   initial begin
      int a0;
      m_tready = 1'b1;
      pause    = '0;
      lat_chk  = 1'b0;
      for (int i = 0; i < N; i++) begin
         src_wr[i]   = 0;
         src_base[i] = 0;
      end

      // lone 3-beat packet from requester 2
      do_reset();
      lat_chk = 1'b1;
      gexp_q.push_back(2);
      send(2, 32'hA0, 3);
      tick();
      check("t1_no_grant_before_arb", 64'(grant_valid), 64'(0));
      tick();
      check("t1_grant_valid", 64'(grant_valid), 64'(1));
      check("t1_grant_idx", 64'(grant_idx), 64'(2));
      wait_drain("t1");
      tick();
      check("t1_released", 64'(grant_valid), 64'(0));
      check("t1_span", 64'(last_out - first_out), 64'(2));

      // all requesters busy with 2-beat packets: rotation plus one bubble per packet
      do_reset();
      lat_chk = 1'b1;
      gexp_q.push_back(0); gexp_q.push_back(1); gexp_q.push_back(2);
      gexp_q.push_back(3); gexp_q.push_back(0);
      send(0, 32'h100, 2);
      send(1, 32'h110, 2);
      send(2, 32'h120, 2);
      send(3, 32'h130, 2);
      send(0, 32'h108, 2);
      wait_drain("t2");
      check("t2_beats", 64'(out_n), 64'(10));
      check("t2_span", 64'(last_out - first_out), 64'(13));

      // owner 1 goes quiet mid-packet; requester 3 must wait
      do_reset();
      gexp_q.push_back(1); gexp_q.push_back(3);
      send(1, 32'h200, 4);
      send(3, 32'h300, 2);
      wait_rd(1, 2, "t3");
      pause[1] = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         check("t3_r3_blocked", 64'(s_tready[3]), 64'(0));
         check("t3_lock_kept", 64'({grant_valid, grant_idx}), 64'({1'b1, 2'd1}));
      end
      pause[1] = 1'b0;
      wait_drain("t3");

      // output stall during a 6-beat packet
      do_reset();
      gexp_q.push_back(0);
      send(0, 32'h400, 6);
      wait_rd(0, 2, "t4");
      a0 = acc_total;
      m_tready = 1'b0;
      tick();
      tick();
      check("t4_stall_accepts", 64'(acc_total - a0), 64'(1));
      m_tready = 1'b1;
      wait_drain("t4");
      check("t4_beats", 64'(out_n), 64'(6));

      // reset in the middle of requester 0's packet, requester 2 waiting
      do_reset();
      gexp_q.push_back(0); gexp_q.push_back(2);
      send(0, 32'h500, 6);
      send(2, 32'h600, 2);
      wait_rd(0, 3, "t5");
      do_reset();
      gexp_q.push_back(0); gexp_q.push_back(2);
      send(0, 32'h700, 2);
      send(2, 32'h600, 2);
      wait_drain("t5");

      // simultaneous single-beat packets from 1 and 2
      do_reset();
      lat_chk = 1'b1;
      gexp_q.push_back(1); gexp_q.push_back(2);
      send(1, 32'h6A0, 1);
      send(2, 32'h6B0, 1);
      wait_drain("t6");
      check("t6_span", 64'(last_out - first_out), 64'(2));

      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/axis_st_pkt_arb.md
# axis_st_pkt_arb

Packet-aware round-robin arbiter that merges N AMBA AXI4-Stream requester streams onto one AXI4-Stream output. It locks the grant to one requester from its first beat until its `tlast` beat is accepted. It sits between several stream masters and a single downstream stream slave. The output passes through a registered full-throughput skid slice so that no downstream `tready` path reaches the requesters combinationally.

## Interface
- `N_REQ`, 4: number of requesters; range 2..16.
- `DATA_W`, 32: `tdata` width in bits; a multiple of 8. `tstrb`/`tkeep` are `DATA_W/8` bits wide.
- `ID_W`, 8: `tid` width.
- `DEST_W`, 4: `tdest` width.
- `USER_W`, 1: `tuser` width.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `s_tvalid`, `s_tready`, `s_tlast`  in/out/in  `N_REQ`  per-requester handshake and `tlast`; bit i belongs to requester i.
- `s_tdata`  in  `N_REQ*DATA_W`  packed; requester i occupies slice [i*DATA_W +: DATA_W].
- `s_tstrb`, `s_tkeep`  in  `N_REQ*DATA_W/8`  packed the same way.
- `s_tid`, `s_tdest`, `s_tuser`  in  `N_REQ*ID_W`, `N_REQ*DEST_W`, `N_REQ*USER_W`  packed the same way.
- `m_tvalid`, `m_tready`  out/in  1  output handshake.
- `m_tdata`, `m_tstrb`, `m_tkeep`, `m_tlast`, `m_tid`, `m_tdest`, `m_tuser`  out  widths as above  output payload.
- `grant_valid`  out  1  an owner is locked.
- `grant_idx`  out  `$clog2(N_REQ)`  index of the current owner.

## Operation
- Two-state FSM:
  - IDLE: no owner.
  - LOCKED: `owner` is fixed.
- IDLE → LOCKED when any `s_tvalid` is 1.
  - `owner` is the first i with `s_tvalid[i]` set, searching from `last_owner+1` upward with wrap modulo `N_REQ`.
  - No beat is accepted in the arbitration cycle.
- In LOCKED:
  - `s_tready[owner] = slice_in_ready`; all other `s_tready` bits are 0.
  - A beat is accepted when `s_tvalid[owner] & s_tready[owner]`. The payload is muxed from slice `owner` into the skid slice.
- Accepted beat with `s_tlast[owner]=1` → IDLE, and `last_owner <= owner`.
- Lock persistence:
  - The lock holds regardless of `s_tvalid` dropping mid-packet.
  - Only an accepted `tlast` beat or `reset` releases it.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,…,N_REQ-1,0.
- Requesters not granted see `s_tready=0` and must hold their payload per AXI4-Stream rules. The arbiter never drops or reorders beats.
- All payload fields pass through unmodified, including `tid`/`tdest`/`tuser`. No packet rewriting.
- Reset values:
  - FSM = IDLE.
  - `last_owner = N_REQ-1`, so requester 0 has first priority.
  - `grant_valid=0`, `grant_idx=0`, `s_tready=0`, `m_tvalid=0`, skid slice empty.
  - `m_tdata`/`m_tstrb`/`m_tkeep`/`m_tlast`/`m_tid`/`m_tdest`/`m_tuser` = 0.
- Reset mid-packet discards any partial packet held in the slice. Requesters are re-arbitrated from requester 0 priority.

## Timing
- Arbitration takes 1 cycle. `grant_valid`/`grant_idx` are registered and update on the cycle LOCKED is entered.
- A requester's first beat can be accepted in the first LOCKED cycle.
- Each packet costs exactly one bubble cycle on the input side. Single-beat packets therefore sustain at most 1 beat per 2 cycles.
- Latency from input acceptance to `m_tvalid` is 1 cycle.
- Skid slice:
  - 2 entries.
  - `slice_in_ready` is registered and equals "skid entry empty".
  - Sustains 1 beat/cycle while `m_tready=1`.
  - After `m_tready` deasserts, at most 1 further beat is absorbed, then `s_tready` drops on the next cycle.
- `m_*` payload holds stable while `m_tvalid=1 & m_tready=0`.
- Simultaneous release and request: the cycle the `tlast` beat is accepted, the FSM goes IDLE. The next arbitration happens on the following cycle and includes the just-released requester, which now has lowest priority.

## Structure
- Package `axis_st_pkt_arb_pkg`:
  - FSM state enum `{ST_IDLE, ST_LOCKED}`.
  - `function rr_next(req, last)`, the round-robin search.
- Sub-module `axis_st_reg_slice`: a parameterized 2-entry skid buffer carrying `{tdata,tstrb,tkeep,tlast,tid,tdest,tuser}`. It is reusable elsewhere in the AXI-Stream components.
- Top module: FSM, owner/last_owner registers, input mux.

## Test plan
- Reset, then only requester 2 sends a 3-beat packet (`tdata` 0xA0,0xA1,0xA2), `m_tready=1`:
  - `grant_idx=2` one cycle after `s_tvalid[2]`.
  - Beats appear on `m_*` in order with 1-cycle latency.
  - `tlast` is on 0xA2.
  - `grant_valid` returns to 0 after that beat.
- All 4 requesters continuously send 2-beat packets:
  - Grant order 0,1,2,3,0.
  - No beat interleaving between packets on `m_*`.
  - One bubble cycle between packets.
- Requester 1 is locked mid-packet, drops `s_tvalid` for 5 cycles while requester 3 is valid:
  - Lock stays on 1.
  - `s_tready[3]=0` throughout.
  - Requester 3 is granted only after requester 1's `tlast` is accepted.
- `m_tready` toggles 1,0,0,1 during a 6-beat packet:
  - All 6 beats delivered exactly once, in order.
  - `m_*` stable during stall.
  - At most 1 beat accepted after `m_tready` falls.
- Assert `reset` for 1 cycle in the middle of requester 0's packet while requester 2 is valid:
  - All outputs at reset values next cycle.
  - Requester 0 is granted first afterwards.
- Single-beat packets (`tlast=1`) from requesters 1 and 2 arrive in the same cycle:
  - Grants 1 then 2.
  - Each is accepted in its first LOCKED cycle.
  - `m_tlast=1` on both output beats.
